dmem_port_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters.
  - Port 0: core load/store path.
  - Port 1: debug/loader path that preloads or inspects DMEM.
- Round-robin arbitration with a request/grant handshake.
- Sequences each transaction through a small FSM: accept, issue, response.
- Sits between the core's ALU-address/store-data path and the DMEM instance.
- Port 0 stalls the core PC while it waits for completion.

---
 rtl/dmem_port_arbiter_if.sv | 56 +++++
 rtl/dmem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_port_arbiter_if.sv
// rtl/dmem_port_arbiter_if.sv - requester, DMEM and counter signals of the DMEM port arbiter
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_gnt;
  logic              p0_done;
  logic              p0_err;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt;
  logic              p1_done;
  logic              p1_err;
  logic [DATA_W-1:0] p1_rdata;

  logic              core_stall;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [CNT_W-1:0]  cnt_p0_grants;
  logic [CNT_W-1:0]  cnt_p1_grants;
  logic [CNT_W-1:0]  cnt_conflicts;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_rdata,
    output p0_gnt, p0_done, p0_err, p0_rdata,
    output p1_gnt, p1_done, p1_err, p1_rdata,
    output core_stall, mem_en, mem_we, mem_addr, mem_wdata,
    output cnt_p0_grants, cnt_p1_grants, cnt_conflicts
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_rdata,
    input  p0_gnt, p0_done, p0_err, p0_rdata,
    input  p1_gnt, p1_done, p1_err, p1_rdata,
    input  core_stall, mem_en, mem_we, mem_addr, mem_wdata,
    input  cnt_p0_grants, cnt_p1_grants, cnt_conflicts
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - round-robin sharing of the single-port DMEM between core (p0) and debug (p1)
// Performance counters are built only when DMEM_ARB_PERF_EN is defined.
module dmem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  dmem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state, state_nxt;
  logic              rr_last;
  logic              own;
  logic              l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              gnt0, gnt1, done_any, err_any, men, mwe;
  logic              aligned;

  assign aligned = (l_addr[1:0] == 2'b00);

  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    done_any  = 1'b0;
    err_any   = 1'b0;
    men       = 1'b0;
    mwe       = 1'b0;
    case (state)
      IDLE: begin
        // rr_last names the previous winner; the other port wins a conflict
        gnt0 = bus.p0_req && (!bus.p1_req || rr_last);
        gnt1 = bus.p1_req && (!bus.p0_req || !rr_last);
        if (gnt0 || gnt1) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (aligned) begin
          men = 1'b1;
          mwe = l_we;
          if (l_we) begin
            done_any  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = RESP;
          end
        end else begin
          done_any  = 1'b1;
          err_any   = 1'b1;
          state_nxt = IDLE;
        end
      end
      RESP: begin
        done_any  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A reset sampled this cycle must not let a write or completion escape
    if (!rst_n) begin
      gnt0     = 1'b0;
      gnt1     = 1'b0;
      done_any = 1'b0;
      err_any  = 1'b0;
      men      = 1'b0;
      mwe      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_last  <= 1'b1;
      own      <= 1'b0;
      l_we     <= 1'b0;
      l_addr   <= '0;
      l_wdata  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state <= state_nxt;
      if (gnt0 || gnt1) begin
        own     <= gnt1;
        rr_last <= gnt1;
        l_we    <= gnt1 ? bus.p1_we    : bus.p0_we;
        l_addr  <= gnt1 ? bus.p1_addr  : bus.p0_addr;
        l_wdata <= gnt1 ? bus.p1_wdata : bus.p0_wdata;
      end
      if (state == RESP) begin
        if (own) rdata1_q <= bus.mem_rdata;
        else     rdata0_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.p0_gnt   = gnt0;
  assign bus.p1_gnt   = gnt1;
  assign bus.p0_done  = done_any && !own;
  assign bus.p1_done  = done_any && own;
  assign bus.p0_err   = err_any && !own;
  assign bus.p1_err   = err_any && own;
  assign bus.p0_rdata = (state == RESP && !own) ? bus.mem_rdata : rdata0_q;
  assign bus.p1_rdata = (state == RESP && own)  ? bus.mem_rdata : rdata1_q;

  assign bus.core_stall = (bus.p0_req || (state != IDLE && !own)) && !bus.p0_done;

  assign bus.mem_en    = men;
  assign bus.mem_we    = mwe;
  assign bus.mem_addr  = l_addr;
  assign bus.mem_wdata = l_wdata;

`ifdef DMEM_ARB_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt0_q, cnt1_q, cntc_q;
  logic             conflict;

  assign conflict = (gnt0 || gnt1) && bus.p0_req && bus.p1_req;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
      cntc_q <= '0;
    end else begin
      if (gnt0 && cnt0_q != '1)     cnt0_q <= cnt0_q + CNT_ONE;
      if (gnt1 && cnt1_q != '1)     cnt1_q <= cnt1_q + CNT_ONE;
      if (conflict && cntc_q != '1) cntc_q <= cntc_q + CNT_ONE;
    end
  end

  assign bus.cnt_p0_grants = cnt0_q;
  assign bus.cnt_p1_grants = cnt1_q;
  assign bus.cnt_conflicts = cntc_q;
`else
  assign bus.cnt_p0_grants = {CNT_W{1'b0}};
  assign bus.cnt_p1_grants = {CNT_W{1'b0}};
  assign bus.cnt_conflicts = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - self-checking bench for dmem_port_arbiter (tables, corner sequences, random vs. model)
module tb_dmem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus ();

  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // DMEM: 128 words, synchronous read
  logic [31:0] mem [0:127] = '{default: 32'h0};
  logic [31:0] rd_q = 32'h0;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[8:2]] <= bus.mem_wdata;
      else            rd_q <= mem[bus.mem_addr[8:2]];
    end
  end
  assign bus.mem_rdata = rd_q;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input int p, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (p == 0) begin
      bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata;
    end else begin
      bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata;
    end
  endtask

  function automatic logic gnt_of(input int p);
    return (p == 0) ? bus.p0_gnt : bus.p1_gnt;
  endfunction
  function automatic logic done_of(input int p);
    return (p == 0) ? bus.p0_done : bus.p1_done;
  endfunction
  function automatic logic err_of(input int p);
    return (p == 0) ? bus.p0_err : bus.p1_err;
  endfunction
  function automatic logic [31:0] rdata_of(input int p);
    return (p == 0) ? bus.p0_rdata : bus.p1_rdata;
  endfunction

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  // reference model state for the random phase
  int          cyc, free_at, rr, w, iss_cyc;
  logic        active[2], cwe[2], pend[2], perr[2], pread[2];
  logic [31:0] caddr[2], cwdata[2], prd[2];
  int          pdone[2];
  logic        iss_al, iss_we;
  logic [31:0] iss_addr, iss_wdata;
  logic [31:0] ref_mem [0:127];
  logic        e_done[2];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        got, m_en, m_we, stall_d, errv, al, e_stall;
    logic [31:0] m_addr, rdv, a;
    int          t, lat;

    vecs[0] = '{0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1, 32'h0};
    vecs[1] = '{0, 1'b0, 32'h10, 32'h0,        1'b0, 2, 32'hDEADBEEF};
    vecs[2] = '{1, 1'b1, 32'h13, 32'h0BADF00D, 1'b1, 1, 32'h0};
    vecs[3] = '{0, 1'b0, 32'h10, 32'h0,        1'b0, 2, 32'hDEADBEEF};
    vecs[4] = '{1, 1'b1, 32'h20, 32'h12345678, 1'b0, 1, 32'h0};
    vecs[5] = '{1, 1'b0, 32'h20, 32'h0,        1'b0, 2, 32'h12345678};
    vecs[6] = '{1, 1'b0, 32'h10, 32'h0,        1'b0, 2, 32'hDEADBEEF};
    vecs[7] = '{0, 1'b0, 32'h42, 32'h0,        1'b1, 1, 32'h0};

    // reset state, with both requests asserted to show grants are suppressed
    drive(0, 1'b1, 1'b1, 32'h10, 32'h55);
    drive(1, 1'b1, 1'b1, 32'h14, 32'h66);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst p0_gnt", bus.p0_gnt, 0);
    check("rst p1_gnt", bus.p1_gnt, 0);
    check("rst p0_done", bus.p0_done, 0);
    check("rst p1_done", bus.p1_done, 0);
    check("rst p0_err", bus.p0_err, 0);
    check("rst p1_err", bus.p1_err, 0);
    check("rst mem_en", bus.mem_en, 0);
    check("rst mem_we", bus.mem_we, 0);
    check("rst mem_addr", bus.mem_addr, 0);
    check("rst mem_wdata", bus.mem_wdata, 0);
    check("rst p0_rdata", bus.p0_rdata, 0);
    check("rst p1_rdata", bus.p1_rdata, 0);
    check("rst cnt_p0", bus.cnt_p0_grants, 0);
    check("rst cnt_p1", bus.cnt_p1_grants, 0);
    check("rst cnt_conf", bus.cnt_conflicts, 0);

    // held conflicting reads: p0, p1, p0, p1 every 3 cycles, then p0 alone
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(0, 1'b1, 1'b0, 32'h40, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h44, 32'h0);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      check("conf both_gnt", bus.p0_gnt & bus.p1_gnt, 0);
      check("conf p0_gnt", bus.p0_gnt, (k % 3 == 0) && ((k / 3) % 2 == 0));
      check("conf p1_gnt", bus.p1_gnt, (k % 3 == 0) && ((k / 3) % 2 == 1));
      check("conf p0_done", bus.p0_done, (k % 3 == 2) && ((k / 3) % 2 == 0));
      check("conf p1_done", bus.p1_done, (k % 3 == 2) && ((k / 3) % 2 == 1));
      @(posedge clk); #1;
      if (k == 9)  bus.p1_req = 1'b0;
      if (k == 12) bus.p0_req = 1'b0;
    end
    @(negedge clk);
    check("conf last p0_done", bus.p0_done, 1);
`ifdef DMEM_ARB_PERF_EN
    check("cnt_p0_grants", bus.cnt_p0_grants, 3);
    check("cnt_p1_grants", bus.cnt_p1_grants, 2);
    check("cnt_conflicts", bus.cnt_conflicts, 4);
`else
    check("cnt_p0_grants", bus.cnt_p0_grants, 0);
    check("cnt_p1_grants", bus.cnt_p1_grants, 0);
    check("cnt_conflicts", bus.cnt_conflicts, 0);
`endif

    // single transactions from the table
    foreach (vecs[i]) begin
      @(posedge clk); #1;
      drive(vecs[i].port, 1'b1, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      got = 1'b0;
      t = 0;
      while (!got && t < 10) begin
        @(negedge clk);
        if (gnt_of(vecs[i].port)) got = 1'b1;
        else begin @(posedge clk); #1; end
        t++;
      end
      check($sformatf("vec%0d gnt", i), got, 1);
      @(posedge clk); #1;
      drive(vecs[i].port, 1'b0, 1'b0, 32'h0, 32'h0);
      lat = 0; m_en = 0; m_we = 0; m_addr = 0; errv = 0; rdv = 0; stall_d = 0;
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        if (c == 1) begin m_en = bus.mem_en; m_we = bus.mem_we; m_addr = bus.mem_addr; end
        if (lat == 0 && done_of(vecs[i].port)) begin
          lat = c; errv = err_of(vecs[i].port);
          rdv = rdata_of(vecs[i].port); stall_d = bus.core_stall;
        end
        if (c < 4) begin @(posedge clk); #1; end
      end
      check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d err", i), errv, vecs[i].exp_err);
      check($sformatf("vec%0d mem_en", i), m_en, !vecs[i].exp_err);
      if (!vecs[i].exp_err) begin
        check($sformatf("vec%0d mem_we", i), m_we, vecs[i].we);
        check($sformatf("vec%0d mem_addr", i), m_addr, vecs[i].addr);
      end
      if (!vecs[i].we && !vecs[i].exp_err)
        check($sformatf("vec%0d rdata", i), rdv, vecs[i].exp_rdata);
      if (vecs[i].port == 0) check($sformatf("vec%0d stall at done", i), stall_d, 0);
    end

    // reset during ISSUE of a p1 write to 0x20
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b1, 32'h20, 32'hBAD0BAD0);
    got = 1'b0;
    t = 0;
    while (!got && t < 10) begin
      @(negedge clk);
      if (bus.p1_gnt) got = 1'b1;
      else begin @(posedge clk); #1; end
      t++;
    end
    check("rstmid gnt", got, 1);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstmid p1_done", bus.p1_done, 0);
    check("rstmid mem_en", bus.mem_en, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rstmid p1_done late", bus.p1_done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(0, 1'b1, 1'b0, 32'h48, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h4C, 32'h0);
    @(negedge clk);
    check("rstmid word 0x20", mem[8], 32'h12345678);
    check("rstmid first p0_gnt", bus.p0_gnt, 1);
    check("rstmid first p1_gnt", bus.p1_gnt, 0);

    // random traffic against a transaction-level model
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int j = 0; j < 128; j++) ref_mem[j] = 32'h0;
    free_at = 0; rr = 1; iss_cyc = -1;
    iss_al = 0; iss_we = 0; iss_addr = 0; iss_wdata = 0;
    for (int p = 0; p < 2; p++) begin
      active[p] = 0; pend[p] = 0; pdone[p] = -1; perr[p] = 0; pread[p] = 0;
      prd[p] = 0; cwe[p] = 0; caddr[p] = 0; cwdata[p] = 0;
    end
    for (cyc = 0; cyc < 1500; cyc++) begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (!active[p] && $urandom_range(0, 99) < 40) begin
          active[p] = 1'b1;
          cwe[p]    = 1'($urandom_range(0, 1));
          a         = 32'h100 + 32'($urandom_range(0, 63)) * 32'd4;
          if ($urandom_range(0, 4) == 0) a = a + 32'($urandom_range(1, 3));
          caddr[p]  = a;
          cwdata[p] = $urandom;
        end
        drive(p, active[p], cwe[p], caddr[p], cwdata[p]);
      end
      @(negedge clk);
      w = -1;
      if (cyc >= free_at) begin
        if (active[0] && active[1]) w = (rr == 1) ? 0 : 1;
        else if (active[0])         w = 0;
        else if (active[1])         w = 1;
      end
      for (int p = 0; p < 2; p++) e_done[p] = pend[p] && (pdone[p] == cyc);
      e_stall = (active[0] || pend[0]) && !e_done[0];
      check("rnd p0_gnt", bus.p0_gnt, w == 0);
      check("rnd p1_gnt", bus.p1_gnt, w == 1);
      check("rnd p0_done", bus.p0_done, e_done[0]);
      check("rnd p1_done", bus.p1_done, e_done[1]);
      check("rnd p0_err", bus.p0_err, e_done[0] && perr[0]);
      check("rnd p1_err", bus.p1_err, e_done[1] && perr[1]);
      check("rnd core_stall", bus.core_stall, e_stall);
      check("rnd mem_en", bus.mem_en, (iss_cyc == cyc) && iss_al);
      check("rnd mem_we", bus.mem_we, (iss_cyc == cyc) && iss_al && iss_we);
      if (iss_cyc == cyc && iss_al) begin
        check("rnd mem_addr", bus.mem_addr, iss_addr);
        if (iss_we) check("rnd mem_wdata", bus.mem_wdata, iss_wdata);
      end
      for (int p = 0; p < 2; p++) begin
        if (e_done[p] && pread[p]) check($sformatf("rnd p%0d_rdata", p), rdata_of(p), prd[p]);
        if (e_done[p]) pend[p] = 1'b0;
      end
      if (w >= 0) begin
        al        = (caddr[w][1:0] == 2'b00);
        active[w] = 1'b0;
        rr        = w;
        pend[w]   = 1'b1;
        pdone[w]  = cyc + ((!al || cwe[w]) ? 1 : 2);
        perr[w]   = !al;
        pread[w]  = al && !cwe[w];
        prd[w]    = ref_mem[caddr[w][8:2]];
        if (al && cwe[w]) ref_mem[caddr[w][8:2]] = cwdata[w];
        iss_cyc   = cyc + 1;
        iss_al    = al;
        iss_we    = cwe[w];
        iss_addr  = caddr[w];
        iss_wdata = cwdata[w];
        free_at   = pdone[w] + 1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
